// File: rtl/uart_tx_fifo_if.sv
// Write-side and status signals of the buffered 8N1 UART transmitter.
// The master drives the write strobe and data; the slave returns FIFO status and the serial line.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;
    logic                          busy;
    logic                          txd;

    modport master (
        output wr_en, wr_data,
        input  full, empty, level, overflow, busy, txd
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, level, overflow, busy, txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter (idle high, LSB first).
// state | meaning: IDLE - line high, pop when data queued | START - start bit low | DATA - 8 data bits | STOP - stop bit high
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5120,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_fifo_if.slave    bus
);
    localparam int               AW         = $clog2(FIFO_DEPTH);
    localparam int               LW         = AW + 1;
    localparam logic [15:0]      BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0]    LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            txd_q;
    logic            busy_q;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            ovf_q;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);
    assign push  = bus.wr_en && !full;
    assign pop   = (state == IDLE) && !empty;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.txd      = txd_q;

    // Storage needs no reset: pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= bus.wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // txd is loaded one state ahead so the line changes only on register outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= START;
                        txd_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        txd_q    <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd_q   <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        txd_q    <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/timeline reference model checked every cycle,
// plus a line decoder and hand-computed expectations for the directed scenarios.
module tb_uart_tx_fifo;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue plus the elapsed time of the frame on the line.
    logic [7:0] mq[$];
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    logic [7:0] m_byte    = 8'h00;
    bit         m_ovf     = 1'b0;
    bit         m_push, m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_active = 1'b0; m_elapsed = 0; m_ovf = 1'b0;
        end else begin
            m_push = bus.wr_en && (mq.size() < DEPTH);
            m_ovf  = bus.wr_en && (mq.size() == DEPTH);
            m_pop  = !m_active && (mq.size() > 0);
            if (m_active) begin
                m_elapsed++;
                if (m_elapsed == 10 * CPB) m_active = 1'b0;
            end
            if (m_pop) begin
                m_byte = mq.pop_front(); m_active = 1'b1; m_elapsed = 0;
            end
            if (m_push) mq.push_back(bus.wr_data);
        end
    end

    function automatic logic exp_txd();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_elapsed / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("level",    bus.level,    mq.size());
        check("full",     bus.full,     mq.size() == DEPTH);
        check("empty",    bus.empty,    mq.size() == 0);
        check("overflow", bus.overflow, m_ovf);
        check("busy",     bus.busy,     m_active);
        check("txd",      bus.txd,      exp_txd());
    end

    // Line decoder and scenario statistics.
    bit         in_frame = 1'b0;
    int         f_start  = 0;
    int         off, bi;
    logic [7:0] f_byte   = 8'h00;
    logic [7:0] dec[$];
    int         starts[$];
    int         peak = 0, ovf_cnt = 0, busy_cnt = 0;
    bit         full_seen = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && bus.txd === 1'b0) begin
                in_frame = 1'b1; f_start = cyc; starts.push_back(cyc);
            end
            if (in_frame) begin
                off = cyc - f_start;
                if (off % CPB == CPB / 2) begin
                    bi = off / CPB;
                    if (bi == 0) check("start_bit", bus.txd, 0);
                    else if (bi <= 8) f_byte[bi-1] = bus.txd;
                    else begin
                        check("stop_bit", bus.txd, 1);
                        dec.push_back(f_byte);
                        in_frame = 1'b0;
                    end
                end
            end
            if (int'(bus.level) > peak) peak = int'(bus.level);
            if (bus.overflow) ovf_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.full) full_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [7:0] d, output int edge_cyc);
        bus.wr_en = 1'b1; bus.wr_data = d;
        tick();
        edge_cyc = cyc;
        bus.wr_en = 1'b0;
    endtask

    task automatic clear_stats();
        dec.delete(); starts.delete();
        peak = 0; ovf_cnt = 0; busy_cnt = 0; full_seen = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < budget) begin
            tick(); n++;
        end
        check(name, n < budget, 1);
        repeat (4) tick();
    endtask

    task automatic wait_start(input string name, input int budget, output int s);
        int n = 0;
        while (starts.size() == 0 && n < budget) begin
            tick(); n++;
        end
        check(name, starts.size() > 0, 1);
        s = (starts.size() > 0) ? starts[0] : cyc;
    endtask

    function automatic int dec_at(input int i);
        return (dec.size() > i) ? int'(dec[i]) : -1;
    endfunction

    function automatic int start_at(input int i);
        return (starts.size() > i) ? starts[i] : -1000;
    endfunction

    initial begin
        int w, s, n, n0;
        logic [7:0] t2[3];
        t2[0] = 8'h55; t2[1] = 8'h0F; t2[2] = 8'hFF;
        bus.wr_en = 1'b0; bus.wr_data = 8'h00;
        repeat (3) tick();
        check("rst_txd", bus.txd, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.level, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        bus.wr_en = 1'b1; bus.wr_data = 8'h99;
        repeat (2) tick();
        check("rst_wr_ignored", bus.level, 0);
        bus.wr_en = 1'b0; reset = 1'b0;
        repeat (3) tick();

        // Single byte 0xA5 while idle.
        clear_stats();
        write1(8'hA5, w);
        wait_idle("t1_idle", 400);
        check("t1_frames", starts.size(), 1);
        check("t1_latency", start_at(0) - w, 1);
        check("t1_byte", dec_at(0), 32'hA5);
        check("t1_busy_cycles", busy_cnt, 160);

        // Three back-to-back bytes.
        clear_stats();
        for (int i = 0; i < 3; i++) write1(t2[i], w);
        wait_idle("t2_idle", 700);
        check("t2_frames", dec.size(), 3);
        for (int i = 0; i < 3; i++) check("t2_byte", dec_at(i), t2[i]);
        check("t2_gap01", start_at(1) - start_at(0), 161);
        check("t2_gap12", start_at(2) - start_at(1), 161);
        check("t2_peak", peak, 2);

        // Ten writes: eight queue, one in flight, the tenth overflows.
        clear_stats();
        write1(8'h10, n0);
        for (int i = 1; i < 10; i++) write1(8'h10 + 8'(i), w);
        wait_idle("t3_idle", 10 * 161 + 100);
        check("t3_latency", start_at(0) - n0, 1);
        check("t3_peak", peak, 8);
        check("t3_full_seen", full_seen, 1);
        check("t3_overflow_pulses", ovf_cnt, 1);
        check("t3_frames", dec.size(), 9);
        for (int i = 0; i < 9; i++) check("t3_byte", dec_at(i), 32'h10 + i);

        // Full FIFO with a write landing exactly on the pop edge.
        clear_stats();
        for (int i = 0; i < 9; i++) write1(8'h30 + 8'(i), w);
        check("t4_full", bus.full, 1);
        check("t4_level8", bus.level, 8);
        wait_start("t4_start", 50, s);
        n = 0;
        while (cyc < s + 160 && n < 400) begin tick(); n++; end
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
        tick();
        bus.wr_en = 1'b0;
        check("t4_overflow", bus.overflow, 1);
        check("t4_level7", bus.level, 7);
        tick();
        check("t4_overflow_off", bus.overflow, 0);
        wait_idle("t4_idle", 10 * 161 + 100);
        check("t4_frames", dec.size(), 9);
        for (int i = 0; i < 9; i++) check("t4_byte", dec_at(i), 32'h30 + i);
        check("t4_overflow_pulses", ovf_cnt, 1);

        // Reset during data bit 3 of 0xC3 with two bytes queued.
        clear_stats();
        write1(8'hC3, w); write1(8'h3C, w); write1(8'h81, w);
        wait_start("t5_start", 50, s);
        n = 0;
        while (cyc < s + 70 && n < 200) begin tick(); n++; end
        check("t5_pre_txd", bus.txd, 0);
        check("t5_pre_level", bus.level, 2);
        #1 reset = 1'b1;
        #1;
        check("t5_txd", bus.txd, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_level", bus.level, 0);
        check("t5_empty", bus.empty, 1);
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        repeat (3) tick();
        check("t5_wr_ignored", bus.level, 0);
        bus.wr_en = 1'b0; reset = 1'b0;
        n0 = starts.size();
        repeat (300) tick();
        check("t5_no_frame", starts.size() - n0, 0);
        check("t5_txd_after", bus.txd, 1);
        check("t5_busy_after", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
